// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decodes the instruction immediate, forms pc + imm, and
// buffers {imm, target, tag} in a 2-entry skid FIFO with registered ready/valid.
module imm_gen_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [2:0]            itype,
    input  logic                  unsign,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic [DATA_WIDTH-1:0] tgt_out,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam logic [2:0] ItNone = 3'd0;
    localparam logic [2:0] ItI8   = 3'd1;
    localparam logic [2:0] ItI12  = 3'd2;
    localparam logic [2:0] ItI14  = 3'd3;
    localparam logic [2:0] ItI16  = 3'd4;
    localparam logic [2:0] ItI20  = 3'd5;
    localparam logic [2:0] ItI21  = 3'd6;
    localparam logic [2:0] ItI26  = 3'd7;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] tgt;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic                  w_wr_ptr_next;
    logic                  w_rd_ptr_next;
    entry_t                r_mem [2];
    entry_t                r_head;
    entry_t                w_new;
    entry_t                w_head_next;
    logic                  w_accept;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [5:0]            w_i8;
    logic [15:0]           w_i14;
    logic [17:0]           w_i16;
    logic [31:0]           w_i20;
    logic [20:0]           w_i21;
    logic [27:0]           w_i26;
    logic                  w_unused_instr;

    // ---------------------------------------------------------------------------------
    // Immediate decode and target add
    // ---------------------------------------------------------------------------------
    assign w_i8  = (DATA_WIDTH == 64) ? instr[15:10] : {1'b0, instr[14:10]};
    assign w_i14 = {instr[23:10], 2'b00};
    assign w_i16 = {instr[25:10], 2'b00};
    assign w_i20 = {instr[24:5], 12'h000};
    assign w_i21 = {instr[4:0], instr[25:10]};
    assign w_i26 = {instr[9:0], instr[25:10], 2'b00};

    assign w_unused_instr = ^{instr[31:26], instr[15]};

    // Sized casts of signed operands sign-extend without zero-width replications at 32 bits
    always_comb begin
        w_imm = '0;
        case (itype)
            ItNone: w_imm = '0;
            ItI8:   w_imm = DATA_WIDTH'(w_i8);
            ItI12: begin
                if (unsign) w_imm = DATA_WIDTH'(instr[21:10]);
                else        w_imm = DATA_WIDTH'($signed(instr[21:10]));
            end
            ItI14:  w_imm = DATA_WIDTH'($signed(w_i14));
            ItI16:  w_imm = DATA_WIDTH'($signed(w_i16));
            ItI20:  w_imm = DATA_WIDTH'($signed(w_i20));
            ItI21:  w_imm = DATA_WIDTH'($signed(w_i21));
            ItI26:  w_imm = DATA_WIDTH'($signed(w_i26));
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        w_new     = '0;
        w_new.imm = w_imm;
        w_new.tgt = pc + w_imm;
        w_new.tag = tag_in;
    end

    // ---------------------------------------------------------------------------------
    // Occupancy FSM
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) w_state_next = StOne;
                end
                StOne: begin
                    if (w_accept && !w_pop)      w_state_next = StFull;
                    else if (w_pop && !w_accept) w_state_next = StEmpty;
                end
                StFull: begin
                    if (w_pop) w_state_next = StOne;
                end
                default: w_state_next = StEmpty;
            endcase
        end
    end

    // Handshake flags come straight from the state register, never from out_ready
    always_comb begin
        in_ready  = (r_state != StFull);
        out_valid = (r_state != StEmpty);
    end

    assign w_accept = in_valid && in_ready && !flush;
    assign w_pop    = out_valid && out_ready;

    // ---------------------------------------------------------------------------------
    // Storage and head register
    // ---------------------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_next = flush ? 1'b0 : (r_wr_ptr + w_accept);
        w_rd_ptr_next = flush ? 1'b0 : (r_rd_ptr + w_pop);
    end

    // The next head is either a stored entry or the one being written this very edge
    always_comb begin
        if (w_accept && (r_wr_ptr == w_rd_ptr_next)) w_head_next = w_new;
        else                                         w_head_next = r_mem[w_rd_ptr_next];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            if (w_accept) r_mem[r_wr_ptr] <= w_new;
            // Outputs keep their last value once the buffer drains
            if (w_state_next != StEmpty) r_head <= w_head_next;
        end
    end

    assign imm_out = r_head.imm;
    assign tgt_out = r_head.tgt;
    assign tag_out = r_head.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: 32- and 64-bit instances share stimulus and are checked against
// a queue-based model every cycle, plus hand-computed literal expectations.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, unsign, out_ready;
    logic [31:0] instr, pc;
    logic [2:0]  itype;
    logic [4:0]  tag_in;
    logic [63:0] pc64;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [4:0]  tag32, tag64;

    int n_checks = 0;
    int n_errors = 0;

    assign pc64 = {32'h0, pc};

    imm_gen_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .itype(itype), .unsign(unsign), .pc(pc), .tag_in(tag_in),
        .out_valid(vld32), .out_ready(out_ready), .imm_out(imm32), .tgt_out(tgt32),
        .tag_out(tag32)
    );

    imm_gen_stage #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .itype(itype), .unsign(unsign), .pc(pc64), .tag_in(tag_in),
        .out_valid(vld64), .out_ready(out_ready), .imm_out(imm64), .tgt_out(tgt64),
        .tag_out(tag64)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: immediates as plain signed arithmetic on 64-bit integers
    function automatic longint sext(input logic [63:0] x, input int n);
        longint m;
        m = longint'(64'd1) << (n - 1);
        return (longint'(x) ^ m) - m;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] t,
                                            input logic u, input int w);
        longint v;
        case (t)
            3'd1: v = (w == 64) ? longint'(ins[15:10]) : longint'(ins[14:10]);
            3'd2: v = u ? longint'(ins[21:10]) : sext(64'(ins[21:10]), 12);
            3'd3: v = sext(64'(ins[23:10]), 14) * 4;
            3'd4: v = sext(64'(ins[25:10]), 16) * 4;
            3'd5: v = sext(64'(ins[24:5]), 20) * 4096;
            3'd6: v = sext(64'({ins[4:0], ins[25:10]}), 21);
            3'd7: v = sext(64'({ins[9:0], ins[25:10]}), 26) * 4;
            default: v = 0;
        endcase
        if (w == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] ref_tgt(input logic [63:0] p, input logic [63:0] imm,
                                            input int w);
        logic [63:0] s;
        s = p + imm;
        if (w == 32) s = s & 64'hFFFF_FFFF;
        return s;
    endfunction

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [4:0]  tag;
    } ent_t;

    ent_t q32[$];
    ent_t q64[$];

    // Compare at the falling edge, then advance the model for the coming rising edge
    initial begin : cmp
        ent_t e;
        bit   acc, pop;
        forever begin
            @(negedge clk);
            if (rst) begin
                q32.delete();
                q64.delete();
                chk("rst_valid32", 64'(vld32), 64'd0);
                chk("rst_valid64", 64'(vld64), 64'd0);
                chk("rst_imm64", imm64, 64'd0);
            end else begin
                chk("in_ready32", 64'(rdy32), 64'(q32.size() < 2));
                chk("in_ready64", 64'(rdy64), 64'(q64.size() < 2));
                chk("out_valid32", 64'(vld32), 64'(q32.size() != 0));
                chk("out_valid64", 64'(vld64), 64'(q64.size() != 0));
                if (q32.size() != 0) begin
                    chk("imm32", 64'(imm32), q32[0].imm);
                    chk("tgt32", 64'(tgt32), q32[0].tgt);
                    chk("tag32", 64'(tag32), 64'(q32[0].tag));
                end
                if (q64.size() != 0) begin
                    chk("imm64", imm64, q64[0].imm);
                    chk("tgt64", tgt64, q64[0].tgt);
                    chk("tag64", 64'(tag64), 64'(q64[0].tag));
                end
                acc = in_valid && (q32.size() < 2) && !flush;
                pop = (q32.size() != 0) && out_ready;
                if (flush) begin
                    q32.delete();
                    q64.delete();
                end else begin
                    if (pop) begin
                        void'(q32.pop_front());
                        void'(q64.pop_front());
                    end
                    if (acc) begin
                        e.tag = tag_in;
                        e.imm = ref_imm(instr, itype, unsign, 32);
                        e.tgt = ref_tgt(pc64, e.imm, 32);
                        q32.push_back(e);
                        e.imm = ref_imm(instr, itype, unsign, 64);
                        e.tgt = ref_tgt(pc64, e.imm, 64);
                        q64.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [2:0] t, input logic u,
                         input logic [31:0] p, input logic [4:0] g);
        in_valid = 1'b1;
        instr    = i;
        itype    = t;
        unsign   = u;
        pc       = p;
        tag_in   = g;
    endtask

    logic [31:0] vecs [5];
    logic [4:0]  tag_ctr;

    initial begin
        vecs = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_8000, 32'hA5A5_A5A5, 32'h0000_FC1F};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; itype = '0; unsign = 1'b0;
        pc = '0; tag_in = '0; out_ready = 1'b1;
        repeat (3) step();
        chk("reset_valid", 64'(vld32), 64'd0);
        chk("reset_ready", 64'(rdy32), 64'd1);
        chk("reset_imm", 64'(imm32), 64'd0);
        chk("reset_tgt", 64'(tgt32), 64'd0);
        chk("reset_tag", 64'(tag32), 64'd0);

        // I12 signed, accepted on the first edge after reset release
        rst = 1'b0;
        drive(32'h003F_FC00, 3'd2, 1'b0, 32'h1C00_0000, 5'd1);
        step();
        chk("i12s_valid", 64'(vld32), 64'd1);
        chk("i12s_imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("i12s_tgt32", 64'(tgt32), 64'h1BFF_FFFF);
        chk("i12s_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i12s_tgt64", tgt64, 64'h1BFF_FFFF);
        drive(32'h003F_FC00, 3'd2, 1'b1, 32'h1C00_0000, 5'd2);
        step();
        chk("i12u_imm32", 64'(imm32), 64'h0000_0FFF);
        chk("i12u_tgt32", 64'(tgt32), 64'h1C00_0FFF);
        chk("i12u_tag32", 64'(tag32), 64'd2);
        drive(32'h03FF_FFFF, 3'd7, 1'b0, 32'h1C00_0000, 5'd3);
        step();
        chk("i26_imm32", 64'(imm32), 64'hFFFF_FFFC);
        chk("i26_tgt32", 64'(tgt32), 64'h1BFF_FFFC);
        chk("i26_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("i26_tgt64", tgt64, 64'h1BFF_FFFC);
        drive(32'h0000_0800, 3'd4, 1'b0, 32'hFFFF_FFFC, 5'd4);
        step();
        chk("wrap_imm32", 64'(imm32), 64'h0000_0008);
        chk("wrap_tgt32", 64'(tgt32), 64'h0000_0004);
        chk("wrap_tgt64", tgt64, 64'h1_0000_0004);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(vld32), 64'd0);
        chk("drain_hold_imm", 64'(imm32), 64'h0000_0008);

        // Sweep every class over a few words with varying backpressure
        tag_ctr = 5'd8;
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 5; k++) begin
                drive(vecs[k], 3'(t), k[0], (k == 4) ? 32'hFFFF_0000 : 32'h1C00_0000 + k * 4096,
                      tag_ctr);
                out_ready = ((t + k) % 3) != 0;
                tag_ctr = tag_ctr + 5'd1;
                step();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Backpressure: two accepts fill the buffer, tag 3 waits at the input
        out_ready = 1'b0;
        drive(32'h0, 3'd0, 1'b0, 32'h100, 5'd1);
        step();
        chk("bp_ready_one", 64'(rdy32), 64'd1);
        drive(32'h0, 3'd0, 1'b0, 32'h104, 5'd2);
        step();
        chk("bp_ready_full", 64'(rdy32), 64'd0);
        drive(32'h0, 3'd0, 1'b0, 32'h108, 5'd3);
        step();
        chk("bp_hold_tag", 64'(tag32), 64'd1);
        step();
        chk("bp_stable_tag", 64'(tag32), 64'd1);
        chk("bp_stable_tgt", 64'(tgt32), 64'h100);
        out_ready = 1'b1;
        step();
        chk("bp_out_tag2", 64'(tag32), 64'd2);
        chk("bp_ready_again", 64'(rdy32), 64'd1);
        step();
        chk("bp_out_tag3", 64'(tag32), 64'd3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(vld32), 64'd0);

        // Flush while full with a new offer pending
        out_ready = 1'b0;
        drive(32'h0, 3'd0, 1'b0, 32'h200, 5'd4);
        step();
        drive(32'h0, 3'd0, 1'b0, 32'h204, 5'd5);
        step();
        chk("fl_full", 64'(rdy32), 64'd0);
        drive(32'h0, 3'd0, 1'b0, 32'h208, 5'd6);
        flush = 1'b1;
        step();
        chk("fl_valid", 64'(vld32), 64'd0);
        chk("fl_ready", 64'(rdy32), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_dropped", 64'(vld32), 64'd0);

        // Asynchronous reset while one entry is held
        drive(32'h03FF_FFFF, 3'd7, 1'b0, 32'h1C00_0000, 5'd7);
        step();
        chk("ar_valid", 64'(vld32), 64'd1);
        chk("ar_tag", 64'(tag32), 64'd7);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("ar_valid_now", 64'(vld32), 64'd0);
        chk("ar_ready_now", 64'(rdy32), 64'd1);
        chk("ar_imm_now", 64'(imm32), 64'd0);
        chk("ar_tgt_now", 64'(tgt32), 64'd0);
        chk("ar_tag_now", 64'(tag32), 64'd0);
        step();
        rst = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the immediate, PC and target datapath; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, meaning the width of the opaque sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous kill of all buffered entries.
REQ-006 in_valid  input  1  an instruction is offered.
REQ-007 in_ready  output  1  the stage can accept an instruction this cycle.
REQ-008 instr  input  32  instruction word.
REQ-009 itype  input  3  immediate class: 0 NONE, 1 I8, 2 I12, 3 I14, 4 I16, 5 I20, 6 I21, 7 I26.
REQ-010 unsign  input  1  I12 zero-extend select.
REQ-011 pc  input  DATA_WIDTH  PC of the instruction.
REQ-012 tag_in  input  TAG_WIDTH  sideband tag.
REQ-013 out_valid  output  1  the head entry is valid.
REQ-014 out_ready  input  1  downstream accepts the head entry.
REQ-015 imm_out  output  DATA_WIDTH  extended immediate.
REQ-016 tgt_out  output  DATA_WIDTH  pc + imm_out.
REQ-017 tag_out  output  TAG_WIDTH  tag of the head entry.

Function
REQ-018 Immediate rules, extended to DATA_WIDTH: I8 zero-extends instr[14:10] when DATA_WIDTH=32 and instr[15:10] when DATA_WIDTH=64; I12 zero-extends instr[21:10] if unsign=1, else sign-extends it; I14 sign-extends {instr[23:10],2'b0}; I16 sign-extends {instr[25:10],2'b0}; I20 sign-extends {instr[24:5],12'b0} from bit 31; I21 sign-extends {instr[4:0],instr[25:10]}; I26 sign-extends {instr[9:0],instr[25:10],2'b0}; NONE gives 0.
REQ-019 tgt_out SHALL be (pc + imm) modulo 2^DATA_WIDTH, with carry-out discarded.
REQ-020 Both values SHALL be computed combinationally at acceptance and stored in a register; none SHALL be computed from registered outputs.
REQ-021 Accept occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready.
REQ-022 Storage SHALL be a 2-entry FIFO (skid buffer) with count states EMPTY(0), ONE(1) and FULL(2).
REQ-023 in_ready SHALL be 1 when count<2, and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-024 Latency SHALL be 1 cycle: data accepted at edge N is presented with out_valid=1 after edge N.
REQ-025 Throughput SHALL be 1 per cycle when out_ready is held at 1.
REQ-026 Count transitions: accept without pop +1; pop without accept -1; simultaneous accept and pop in ONE leaves count unchanged, with the head advancing to the new entry.
REQ-027 In FULL, accept is impossible (in_ready=0) and pop moves to ONE.
REQ-028 Entries SHALL leave in acceptance order.
REQ-029 Head outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 Flush SHALL set count to 0 at the next edge and discard any same-cycle accept; a same-cycle pop is still counted as consumed by downstream.
REQ-031 While out_valid=0, imm_out, tgt_out and tag_out SHALL hold their last value (don't-care to consumers).
REQ-032 Pointer and count arithmetic SHALL wrap modulo 2 with no overflow or underflow states reachable.

Reset
REQ-033 On rst=1, asynchronously: count=0, out_valid=0, in_ready=1, imm_out=0, tgt_out=0, tag_out=0, both pointers=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, with no partial pop observable.
REQ-035 The first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-036 I12, instr[21:10]=0xFFF, pc=0x1C000000: with unsign=0 -> imm_out=0xFFFFFFFF, tgt_out=0x1BFFFFFF; with unsign=1 -> imm_out=0x00000FFF, tgt_out=0x1C000FFF; each appears 1 cycle after accept.
REQ-037 I26, instr[9:0]=0x3FF, instr[25:10]=0xFFFF, pc=0x1C000000 -> imm_out=0xFFFFFFFC, tgt_out=0x1BFFFFFC; with DATA_WIDTH=64 -> imm_out=0xFFFFFFFFFFFFFFFC.
REQ-038 Wrap: I16, offs16=2, pc=0xFFFFFFFC -> imm_out=0x00000008, tgt_out=0x00000004.
REQ-039 Backpressure: out_ready=0, offer tags 1,2,3 on consecutive cycles -> in_ready falls after 2 accepts and tag 3 is held at input; then out_ready=1 -> outputs tag 1, 2, 3 in order, one per cycle.
REQ-040 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry dropped; rst pulse in ONE -> out_valid=0 immediately and outputs are 0.
